// File: rtl/mdclcg_pkg.sv
// Shared types and defaults for the MDCLCG next-state engine.
// Holds the FSM encoding, default LCG constants and the bit-counter width helper.
// No logic; imported by lcg_csa_iter and csa_row.
package mdclcg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC     = 2'd1,
        RESOLVE = 2'd2
    } lcg_state_t;

    localparam int          N_DEF         = 8;
    localparam logic [7:0]  A_DEF         = 8'd5;
    localparam logic [7:0]  B_DEF         = 8'd3;
    localparam logic [7:0]  SEED_INIT_DEF = 8'd1;

    // Counter width for a given word size; never narrower than one bit.
    function automatic int kw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int KW = kw_of(N_DEF);

endpackage

// File: rtl/csa_row.sv
// Row of N full adders folding one addend into a carry-save pair.
// Latency: combinational, zero cycles.
// Backpressure: none; outputs track inputs continuously.
module csa_row
    import mdclcg_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] s,
    input  logic [N-1:0] c,
    input  logic [N-1:0] addend,
    output logic [N-1:0] sum,
    output logic [N-1:0] carry
);

    logic [N-1:0] maj;

    always_comb begin
        sum = s ^ c ^ addend;
        maj = (s & c) | (s & addend) | (c & addend);
        // Carry out of the MSB is dropped so the pair stays modulo 2^N.
        carry = {maj[N-2:0], 1'b0};
    end

endmodule

// File: rtl/lcg_csa_iter.sv
// Sequential LCG step x <= (A*x + B) mod 2^N via shift-and-add in carry-save form.
// Latency: N+1 clocks from accepted start to valid; one result per N+2 clocks.
// Backpressure: start/seed_ld accepted only in IDLE, ignored while busy, nothing queued.
module lcg_csa_iter
    import mdclcg_pkg::*;
#(
    parameter int           N         = N_DEF,
    parameter logic [N-1:0] A         = A_DEF,
    parameter logic [N-1:0] B         = B_DEF,
    parameter logic [N-1:0] SEED_INIT = SEED_INIT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         seed_ld,
    input  logic [N-1:0] seed,
    input  logic         start,
    output logic [N-1:0] rnd,
    output logic         valid,
    output logic         busy
);

    localparam int CW = kw_of(N);

    lcg_state_t   state, state_nxt;
    logic [N-1:0] x, s, c, m;
    logic [CW-1:0] k;
    logic [N-1:0] addend, row_sum, row_carry, resolved;

    assign addend   = A[k] ? m : '0;
    assign resolved = s + c;
    assign busy     = (state != IDLE);

    csa_row #(.N(N)) u_csa_row (
        .s      (s),
        .c      (c),
        .addend (addend),
        .sum    (row_sum),
        .carry  (row_carry)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACC;
            ACC:     if (k == CW'(N-1)) state_nxt = RESOLVE;
            RESOLVE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x     <= SEED_INIT;
            s     <= '0;
            c     <= '0;
            m     <= '0;
            k     <= '0;
            rnd   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_nxt;
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (seed_ld) x <= seed;
                    if (start) begin
                        // A seed loaded in the same cycle feeds this iteration.
                        s <= B;
                        c <= '0;
                        m <= seed_ld ? seed : x;
                        k <= '0;
                    end
                end
                ACC: begin
                    s <= row_sum;
                    c <= row_carry;
                    m <= m << 1;
                    k <= k + CW'(1);
                end
                RESOLVE: begin
                    x     <= resolved;
                    rnd   <= resolved;
                    valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcg_csa_iter.sv
// Bench for lcg_csa_iter: directed scenarios plus a randomized multi-parameter regression.
module tb_lcg_csa_iter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         seed_ld = 1'b0;
    logic [N-1:0] seed = '0;
    logic         start = 1'b0;

    logic [N-1:0] rnd [4];
    logic         valid [4];
    logic         busy [4];

    // Parameter sets: default, A=0, A=all-ones with B=0, arbitrary.
    localparam logic [7:0] PA [4] = '{8'd5, 8'd0,   8'hFF, 8'h6D};
    localparam logic [7:0] PB [4] = '{8'd3, 8'h77, 8'd0,  8'hA9};

    lcg_csa_iter #(.N(N), .A(8'd5), .B(8'd3), .SEED_INIT(8'd1)) u_dut (
        .clk(clk), .rst_n(rst_n), .seed_ld(seed_ld), .seed(seed), .start(start),
        .rnd(rnd[0]), .valid(valid[0]), .busy(busy[0]));
    lcg_csa_iter #(.N(N), .A(8'd0), .B(8'h77), .SEED_INIT(8'd1)) u_a0 (
        .clk(clk), .rst_n(rst_n), .seed_ld(seed_ld), .seed(seed), .start(start),
        .rnd(rnd[1]), .valid(valid[1]), .busy(busy[1]));
    lcg_csa_iter #(.N(N), .A(8'hFF), .B(8'd0), .SEED_INIT(8'd1)) u_a1 (
        .clk(clk), .rst_n(rst_n), .seed_ld(seed_ld), .seed(seed), .start(start),
        .rnd(rnd[2]), .valid(valid[2]), .busy(busy[2]));
    lcg_csa_iter #(.N(N), .A(8'h6D), .B(8'hA9), .SEED_INIT(8'd1)) u_ax (
        .clk(clk), .rst_n(rst_n), .seed_ld(seed_ld), .seed(seed), .start(start),
        .rnd(rnd[3]), .valid(valid[3]), .busy(busy[3]));

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [7:0] exp_q [$];
    logic [7:0] rq0 [$], rq1 [$], rq2 [$], rq3 [$];

    function automatic logic [7:0] lcg_ref(input logic [7:0] a, input logic [7:0] b, input logic [7:0] x);
        int unsigned t;
        t = int'(a) * int'(x) + int'(b);
        return t[7:0];
    endfunction

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue start (optionally with seed) for exactly one sampling edge.
    task automatic pulse_start(input logic ld, input logic [7:0] sd);
        seed_ld = ld;
        seed    = sd;
        start   = 1'b1;
        cyc(1);
        start   = 1'b0;
        seed_ld = 1'b0;
    endtask

    // Counts edges until main DUT valid is seen; ok=0 on timeout.
    task automatic wait_valid(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            n++;
            if (valid[0]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int n;
        bit ok;
        logic [7:0] e;
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        chk_cnt++; if (rnd[0] !== 8'd0) $display("FAIL reset_rnd: got %0d want 0", rnd[0]); else pass_cnt++;
        chk_cnt++; if (valid[0] !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid[0]); else pass_cnt++;
        chk_cnt++; if (busy[0] !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy[0]); else pass_cnt++;
        exp_q.push_back(lcg_ref(8'd5, 8'd3, 8'd1));
        pulse_start(1'b0, 8'd0);
        chk_cnt++; if (busy[0] !== 1'b1) $display("FAIL first_busy: got %b want 1", busy[0]); else pass_cnt++;
        wait_valid(n, ok);
        e = exp_q.pop_front();
        chk_cnt++; if (!ok || n != 9) $display("FAIL first_latency: got %0d edges (ok=%0b) want 9", n, ok); else pass_cnt++;
        chk_cnt++; if (rnd[0] !== e) $display("FAIL first_rnd: got %0d want %0d", rnd[0], e); else pass_cnt++;
        chk_cnt++; if (busy[0] !== 1'b0) $display("FAIL first_busy_fall: got %b want 0", busy[0]); else pass_cnt++;
    endtask

    // Entered in the valid cycle of the previous result.
    task automatic test_back_to_back;
        int n;
        bit ok;
        logic [7:0] x, e;
        x = rnd[0];
        for (int i = 0; i < 3; i++) begin
            x = lcg_ref(8'd5, 8'd3, x);
            exp_q.push_back(x);
            pulse_start(1'b0, 8'd0);
            wait_valid(n, ok);
            e = exp_q.pop_front();
            chk_cnt++; if (!ok || n + 1 != 10) $display("FAIL b2b_spacing%0d: got %0d want 10", i, n + 1); else pass_cnt++;
            chk_cnt++; if (rnd[0] !== e) $display("FAIL b2b_rnd%0d: got %0d want %0d", i, rnd[0], e); else pass_cnt++;
        end
        cyc(1);
        chk_cnt++; if (valid[0] !== 1'b0) $display("FAIL valid_one_cycle: got %b want 0", valid[0]); else pass_cnt++;
    endtask

    task automatic test_seed_priority;
        int n;
        bit ok;
        logic [7:0] e, prev;
        exp_q.push_back(lcg_ref(8'd5, 8'd3, 8'hFF));
        pulse_start(1'b1, 8'hFF);
        wait_valid(n, ok);
        e = exp_q.pop_front();
        chk_cnt++; if (!ok || rnd[0] !== e) $display("FAIL seed_and_start: got %0d want %0d", rnd[0], e); else pass_cnt++;
        cyc(1);
        prev = rnd[0];
        seed_ld = 1'b1;
        seed = 8'h10;
        cyc(1);
        seed_ld = 1'b0;
        cyc(2);
        chk_cnt++; if (rnd[0] !== prev || valid[0] !== 1'b0) $display("FAIL seed_only_rnd: got %0d want %0d", rnd[0], prev); else pass_cnt++;
        exp_q.push_back(lcg_ref(8'd5, 8'd3, 8'h10));
        pulse_start(1'b0, 8'd0);
        wait_valid(n, ok);
        e = exp_q.pop_front();
        chk_cnt++; if (!ok || rnd[0] !== e) $display("FAIL seed_then_start: got %0d want %0d", rnd[0], e); else pass_cnt++;
    endtask

    task automatic test_ignore_busy;
        int nb, nv;
        bit done;
        logic [7:0] e;
        cyc(1);
        exp_q.push_back(lcg_ref(8'd5, 8'd3, rnd[0]));
        pulse_start(1'b0, 8'd0);
        nb = busy[0] ? 1 : 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (i == 2) begin
                start = 1'b1; seed_ld = 1'b1; seed = 8'd0;
            end
            cyc(1);
            start = 1'b0; seed_ld = 1'b0;
            if (valid[0]) done = 1'b1;
            else if (busy[0]) nb++;
        end
        e = exp_q.pop_front();
        chk_cnt++; if (!done || rnd[0] !== e) $display("FAIL ignore_rnd: got %0d want %0d", rnd[0], e); else pass_cnt++;
        chk_cnt++; if (nb != 9) $display("FAIL busy_width: got %0d want 9", nb); else pass_cnt++;
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            cyc(1);
            if (valid[0]) nv++;
        end
        chk_cnt++; if (nv != 0 || busy[0] !== 1'b0) $display("FAIL no_extra_iter: got %0d pulses want 0", nv); else pass_cnt++;
    endtask

    task automatic test_mid_reset;
        int n, nv;
        bit ok;
        logic [7:0] e;
        pulse_start(1'b0, 8'd0);
        cyc(4);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (valid[0]) nv++;
        end
        chk_cnt++; if (nv != 0) $display("FAIL midrst_no_valid: got %0d pulses want 0", nv); else pass_cnt++;
        chk_cnt++; if (rnd[0] !== 8'd0 || busy[0] !== 1'b0) $display("FAIL midrst_state: got rnd=%0d busy=%b want 0/0", rnd[0], busy[0]); else pass_cnt++;
        exp_q.push_back(lcg_ref(8'd5, 8'd3, 8'd1));
        pulse_start(1'b0, 8'd0);
        wait_valid(n, ok);
        e = exp_q.pop_front();
        chk_cnt++; if (!ok || rnd[0] !== e) $display("FAIL midrst_restart: got %0d want %0d", rnd[0], e); else pass_cnt++;
    endtask

    task automatic test_random;
        int n;
        bit ok;
        logic [7:0] sd, e0, e1, e2, e3;
        for (int it = 0; it < 1000; it++) begin
            sd = 8'($urandom);
            rq0.push_back(lcg_ref(PA[0], PB[0], sd));
            rq1.push_back(lcg_ref(PA[1], PB[1], sd));
            rq2.push_back(lcg_ref(PA[2], PB[2], sd));
            rq3.push_back(lcg_ref(PA[3], PB[3], sd));
            pulse_start(1'b1, sd);
            wait_valid(n, ok);
            e0 = rq0.pop_front(); e1 = rq1.pop_front();
            e2 = rq2.pop_front(); e3 = rq3.pop_front();
            chk_cnt++; if (!ok || rnd[0] !== e0) $display("FAIL rand_a5 seed=%0d: got %0d want %0d", sd, rnd[0], e0); else pass_cnt++;
            chk_cnt++; if (valid[1] !== 1'b1 || rnd[1] !== e1) $display("FAIL rand_a0 seed=%0d: got %0d want %0d", sd, rnd[1], e1); else pass_cnt++;
            chk_cnt++; if (valid[2] !== 1'b1 || rnd[2] !== e2) $display("FAIL rand_aff seed=%0d: got %0d want %0d", sd, rnd[2], e2); else pass_cnt++;
            chk_cnt++; if (valid[3] !== 1'b1 || rnd[3] !== e3) $display("FAIL rand_a6d seed=%0d: got %0d want %0d", sd, rnd[3], e3); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_seed_priority;
        test_ignore_busy;
        test_mid_reset;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
